// File: rtl/dmem_responder.sv
// Data-memory responder: accepts single read/write requests on strobe rising
// edges, performs the access on an internal word array after LATENCY cycles,
// and signals completion with a one-cycle done (and optional err) pulse.
module dmem_responder #(
    parameter int DATA_W  = 24,
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              DRAM_read,
    input  logic              DRAM_write,
    input  logic [DATA_W-1:0] DMEM_addr,
    input  logic [DATA_W-1:0] TO_DMEM,
    output logic [DATA_W-1:0] FROM_DMEM,
    output logic              DMEM_busy,
    output logic              DMEM_done,
    output logic              DMEM_err
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    logic [1:0]        state;
    logic [3:0]        cnt;
    logic              rd_q, wr_q;
    logic              req_rd, req_wr;
    logic [DATA_W-1:0] addr_l, data_l;

    logic rd_rise, wr_rise, oor, conflict, exec, mem_we;

    always_comb begin
        rd_rise  = DRAM_read & ~rd_q;
        wr_rise  = DRAM_write & ~wr_q;
        // Upper address bits set means the word lies outside the array; no aliasing.
        oor      = |addr_l[DATA_W-1:ADDR_W];
        conflict = req_rd & req_wr;
        exec     = (state == BUSY) && (cnt == 4'd0);
        mem_we   = exec && req_wr && !req_rd && !oor;
    end

    // Strobe history for edge detection, tracked in every state.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_q <= 1'b0;
            wr_q <= 1'b0;
        end else begin
            rd_q <= DRAM_read;
            wr_q <= DRAM_write;
        end
    end

    // Request FSM: accept in IDLE, count down in BUSY, pulse completion in RESP.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            req_rd    <= 1'b0;
            req_wr    <= 1'b0;
            addr_l    <= '0;
            data_l    <= '0;
            FROM_DMEM <= '0;
            DMEM_busy <= 1'b0;
            DMEM_done <= 1'b0;
            DMEM_err  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (rd_rise | wr_rise) begin
                        addr_l    <= DMEM_addr;
                        data_l    <= TO_DMEM;
                        req_rd    <= rd_rise;
                        req_wr    <= wr_rise;
                        cnt       <= LAT_M1;
                        state     <= BUSY;
                        DMEM_busy <= 1'b1;
                    end
                end
                BUSY: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        state     <= RESP;
                        DMEM_busy <= 1'b0;
                        DMEM_done <= 1'b1;
                        DMEM_err  <= oor | conflict;
                        // Simultaneous strobes leave read data untouched.
                        if (req_rd && !conflict)
                            FROM_DMEM <= oor ? '0 : mem[addr_l[ADDR_W-1:0]];
                    end
                end
                RESP: begin
                    DMEM_done <= 1'b0;
                    DMEM_err  <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Array write port; contents survive reset, but reset blocks a pending commit.
    always_ff @(posedge clk) begin
        if (reset_n && mem_we)
            mem[addr_l[ADDR_W-1:0]] <= data_l;
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: cycle table for LATENCY=2 plus hand
// sequences for LATENCY=1 and strobe-held-through-reset.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        rd, wr;
    logic [23:0] addr, wdata;
    logic [23:0] from2, from1;
    logic        busy2, done2, err2, busy1, done1, err1;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DATA_W(24), .ADDR_W(8), .LATENCY(2)) dut (
        .clk(clk), .reset_n(reset_n), .DRAM_read(rd), .DRAM_write(wr),
        .DMEM_addr(addr), .TO_DMEM(wdata), .FROM_DMEM(from2),
        .DMEM_busy(busy2), .DMEM_done(done2), .DMEM_err(err2));

    dmem_responder #(.DATA_W(24), .ADDR_W(8), .LATENCY(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .DRAM_read(rd), .DRAM_write(wr),
        .DMEM_addr(addr), .TO_DMEM(wdata), .FROM_DMEM(from1),
        .DMEM_busy(busy1), .DMEM_done(done1), .DMEM_err(err1));

    typedef struct {
        logic        rst, r, w;
        logic [23:0] a, d;
        logic        b, dn, e;
        logic [23:0] f;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic rst, logic r, logic w, logic [23:0] a, logic [23:0] d,
                                logic b, logic dn, logic e, logic [23:0] f);
        vec_t v;
        v.rst = rst; v.r = r; v.w = w; v.a = a; v.d = d;
        v.b = b; v.dn = dn; v.e = e; v.f = f;
        return v;
    endfunction

    task automatic chk(string nm, logic [23:0] got, logic [23:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic drive(logic rst, logic r, logic w, logic [23:0] a, logic [23:0] d);
        @(negedge clk);
        reset_n = rst; rd = r; wr = w; addr = a; wdata = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
        tick(); tick();
        chk("rst from",  from2, 24'd0);
        chk("rst busy",  {23'd0, busy2}, 24'd0);
        chk("rst done",  {23'd0, done2}, 24'd0);
        chk("rst err",   {23'd0, err2},  24'd0);
        chk("rst from1", from1, 24'd0);

        // rst r w addr data | busy done err from
        // case 1: write 32 to addr 5
        tbl.push_back(mk(1,0,1,24'd5,24'd32,      1,0,0,24'd0));
        tbl.push_back(mk(1,0,1,24'd5,24'd32,      1,0,0,24'd0));
        tbl.push_back(mk(1,0,0,24'd0,24'd0,       0,1,0,24'd0));
        tbl.push_back(mk(1,0,0,24'd0,24'd0,       0,0,0,24'd0));
        // case 2: read addr 5
        tbl.push_back(mk(1,1,0,24'd5,24'd0,       1,0,0,24'd0));
        tbl.push_back(mk(1,0,0,24'd5,24'd0,       1,0,0,24'd0));
        tbl.push_back(mk(1,0,0,24'd0,24'd0,       0,1,0,24'd32));
        tbl.push_back(mk(1,0,0,24'd0,24'd0,       0,0,0,24'd32));
        // write ABCDEF to addr 0; FROM_DMEM holds
        tbl.push_back(mk(1,0,1,24'd0,24'hABCDEF,  1,0,0,24'd32));
        tbl.push_back(mk(1,0,0,24'd0,24'hABCDEF,  1,0,0,24'd32));
        tbl.push_back(mk(1,0,0,24'd0,24'd0,       0,1,0,24'd32));
        tbl.push_back(mk(1,0,0,24'd0,24'd0,       0,0,0,24'd32));
        // case 3: read held high, write toggled while busy/resp
        tbl.push_back(mk(1,1,0,24'd5,24'd99,      1,0,0,24'd32));
        tbl.push_back(mk(1,1,1,24'd5,24'd99,      1,0,0,24'd32));
        tbl.push_back(mk(1,1,0,24'd5,24'd99,      0,1,0,24'd32));
        tbl.push_back(mk(1,1,1,24'd5,24'd99,      0,0,0,24'd32));
        tbl.push_back(mk(1,1,0,24'd5,24'd99,      0,0,0,24'd32));
        tbl.push_back(mk(1,1,0,24'd5,24'd99,      0,0,0,24'd32));
        tbl.push_back(mk(1,0,0,24'd5,24'd0,       0,0,0,24'd32));
        // addr 5 must still hold 32
        tbl.push_back(mk(1,1,0,24'd5,24'd0,       1,0,0,24'd32));
        tbl.push_back(mk(1,0,0,24'd5,24'd0,       1,0,0,24'd32));
        tbl.push_back(mk(1,0,0,24'd0,24'd0,       0,1,0,24'd32));
        tbl.push_back(mk(1,0,0,24'd0,24'd0,       0,0,0,24'd32));
        // case 4: out-of-range read, then out-of-range write, then read addr 0
        tbl.push_back(mk(1,1,0,24'h000100,24'd0,  1,0,0,24'd32));
        tbl.push_back(mk(1,0,0,24'h000100,24'd0,  1,0,0,24'd32));
        tbl.push_back(mk(1,0,0,24'd0,24'd0,       0,1,1,24'd0));
        tbl.push_back(mk(1,0,0,24'd0,24'd0,       0,0,0,24'd0));
        tbl.push_back(mk(1,0,1,24'h000100,24'd7,  1,0,0,24'd0));
        tbl.push_back(mk(1,0,0,24'h000100,24'd7,  1,0,0,24'd0));
        tbl.push_back(mk(1,0,0,24'd0,24'd0,       0,1,1,24'd0));
        tbl.push_back(mk(1,0,0,24'd0,24'd0,       0,0,0,24'd0));
        tbl.push_back(mk(1,1,0,24'd0,24'd0,       1,0,0,24'd0));
        tbl.push_back(mk(1,0,0,24'd0,24'd0,       1,0,0,24'd0));
        tbl.push_back(mk(1,0,0,24'd0,24'd0,       0,1,0,24'hABCDEF));
        tbl.push_back(mk(1,0,0,24'd0,24'd0,       0,0,0,24'hABCDEF));
        // case 5: both strobes together, then addr 5 still 32
        tbl.push_back(mk(1,1,1,24'd5,24'd77,      1,0,0,24'hABCDEF));
        tbl.push_back(mk(1,0,0,24'd5,24'd77,      1,0,0,24'hABCDEF));
        tbl.push_back(mk(1,0,0,24'd0,24'd0,       0,1,1,24'hABCDEF));
        tbl.push_back(mk(1,0,0,24'd0,24'd0,       0,0,0,24'hABCDEF));
        tbl.push_back(mk(1,1,0,24'd5,24'd0,       1,0,0,24'hABCDEF));
        tbl.push_back(mk(1,0,0,24'd5,24'd0,       1,0,0,24'hABCDEF));
        tbl.push_back(mk(1,0,0,24'd0,24'd0,       0,1,0,24'd32));
        tbl.push_back(mk(1,0,0,24'd0,24'd0,       0,0,0,24'd32));
        // case 6: write 0 to addr 7, then write 9 aborted by reset
        tbl.push_back(mk(1,0,1,24'd7,24'd0,       1,0,0,24'd32));
        tbl.push_back(mk(1,0,0,24'd7,24'd0,       1,0,0,24'd32));
        tbl.push_back(mk(1,0,0,24'd0,24'd0,       0,1,0,24'd32));
        tbl.push_back(mk(1,0,0,24'd0,24'd0,       0,0,0,24'd32));
        tbl.push_back(mk(1,0,1,24'd7,24'd9,       1,0,0,24'd32));
        tbl.push_back(mk(0,0,0,24'd7,24'd9,       0,0,0,24'd0));
        tbl.push_back(mk(1,0,0,24'd0,24'd0,       0,0,0,24'd0));
        tbl.push_back(mk(1,0,0,24'd0,24'd0,       0,0,0,24'd0));
        tbl.push_back(mk(1,1,0,24'd5,24'd0,       1,0,0,24'd0));
        tbl.push_back(mk(1,0,0,24'd5,24'd0,       1,0,0,24'd0));
        tbl.push_back(mk(1,0,0,24'd0,24'd0,       0,1,0,24'd32));
        tbl.push_back(mk(1,0,0,24'd0,24'd0,       0,0,0,24'd32));
        tbl.push_back(mk(1,1,0,24'd7,24'd0,       1,0,0,24'd32));
        tbl.push_back(mk(1,0,0,24'd7,24'd0,       1,0,0,24'd32));
        tbl.push_back(mk(1,0,0,24'd0,24'd0,       0,1,0,24'd0));
        tbl.push_back(mk(1,0,0,24'd0,24'd0,       0,0,0,24'd0));

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].d);
            tick();
            chk($sformatf("row%0d busy", i), {23'd0, busy2}, {23'd0, tbl[i].b});
            chk($sformatf("row%0d done", i), {23'd0, done2}, {23'd0, tbl[i].dn});
            chk($sformatf("row%0d err",  i), {23'd0, err2},  {23'd0, tbl[i].e});
            chk($sformatf("row%0d from", i), from2, tbl[i].f);
        end

        // LATENCY=1: reset, write 32 to addr 5, done one edge after accept
        drive(0, 0, 0, 24'd0, 24'd0); tick();
        drive(1, 0, 1, 24'd5, 24'd32); tick();
        chk("l1 wr busy k",   {23'd0, busy1}, 24'd1);
        chk("l1 wr done k",   {23'd0, done1}, 24'd0);
        drive(1, 0, 0, 24'd0, 24'd0); tick();
        chk("l1 wr busy k+1", {23'd0, busy1}, 24'd0);
        chk("l1 wr done k+1", {23'd0, done1}, 24'd1);
        chk("l1 wr err k+1",  {23'd0, err1},  24'd0);
        tick();
        chk("l1 wr done k+2", {23'd0, done1}, 24'd0);

        // read strobe already high during reset counts as a request afterwards
        drive(0, 1, 0, 24'd5, 24'd0); tick();
        chk("l1 rst from",    from1, 24'd0);
        chk("l1 rst busy",    {23'd0, busy1}, 24'd0);
        drive(1, 1, 0, 24'd5, 24'd0); tick();
        chk("l1 rd busy k",   {23'd0, busy1}, 24'd1);
        tick();
        chk("l1 rd done k+1", {23'd0, done1}, 24'd1);
        chk("l1 rd from k+1", from1, 24'd32);
        tick();
        chk("l1 rd done k+2", {23'd0, done1}, 24'd0);
        tick();
        chk("l1 held busy",   {23'd0, busy1}, 24'd0);
        chk("l1 held from",   from1, 24'd32);
        drive(1, 0, 0, 24'd0, 24'd0); tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
